// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between requester agents and the round-robin arbiter
// that owns the shared 8:1 mux select.
interface rr_mux_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] sel;
  logic       timeout;

  // Requester side: raises requests and signals completion.
  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  sel,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output sel,
    output timeout
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for one shared 8:1 datapath: registered one-hot grant,
// binary mux select, hold timeout, and a mandatory idle bubble after every release.
module rr_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_mux_arbiter_if.slave      bus
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam bit         HOLD_EN    = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       gv_q, gv_d;
  logic       timeout_q, timeout_d;

  logic [2:0] winner;
  logic       found;
  logic       owner_release;
  logic       hold_expired;

  // Search starts just after the last winner; k = 8 wraps back onto last_q,
  // which is what gives the just-released requester the lowest priority.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!found && bus.req[last_q + 3'(k)]) begin
        winner = last_q + 3'(k);
        found  = 1'b1;
      end
    end
  end

  assign owner_release = bus.done || !bus.req[sel_q];
  assign hold_expired  = HOLD_EN && (hold_cnt_q == HOLD_LIMIT);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    gv_d       = gv_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = 8'b1 << winner;
          sel_d      = winner;
          gv_d       = 1'b1;
          hold_cnt_d = 8'd1;
          state_d    = GRANTED;
        end
      end
      GRANTED: begin
        if (owner_release || hold_expired) begin
          // sel keeps the released index; a concurrent done masks the timeout pulse.
          grant_d    = 8'h00;
          gv_d       = 1'b0;
          last_d     = sel_q;
          hold_cnt_d = 8'd0;
          timeout_d  = !owner_release;
          state_d    = IDLE;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 3'd7;
      sel_q      <= 3'd0;
      grant_q    <= 8'h00;
      gv_q       <= 1'b0;
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      gv_q       <= gv_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.sel         = sel_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed vector table, rotation and
// asynchronous-reset sequences, then random traffic against a behavioural model.
module tb_rr_mux_arbiter;

  localparam int MAXH = 4;

  logic clk;
  logic rst;
  rr_mux_arbiter_if bus ();

  rr_mux_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       gv;
    logic [2:0] sel;
    logic       to;
  } vec_t;

  vec_t vecs [22];

  // Behavioural model: owner is -1 when nobody holds the path.
  int         m_owner;
  int         m_last;
  int         m_held;
  logic [2:0] m_sel;
  logic       m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic gv,
                         input logic [2:0] s, input logic to);
    chk({tag, " grant"},       32'(bus.grant),       32'(g));
    chk({tag, " grant_valid"}, 32'(bus.grant_valid), 32'(gv));
    chk({tag, " sel"},         32'(bus.sel),         32'(s));
    chk({tag, " timeout"},     32'(bus.timeout),     32'(to));
  endtask

  task automatic cycle(input logic [7:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 7;
    m_held  = 0;
    m_sel   = 3'd0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] r, input logic d);
    bit picked;
    m_to = 1'b0;
    if (m_owner < 0) begin
      picked = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_last + k) % 8;
        if (!picked && r[c]) begin
          m_owner = c;
          picked  = 1'b1;
        end
      end
      if (picked) begin
        m_sel  = 3'(m_owner);
        m_held = 1;
      end
    end else if (d || !r[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
      m_held  = 0;
    end else if (MAXH != 0 && m_held == MAXH) begin
      m_last  = m_owner;
      m_owner = -1;
      m_held  = 0;
      m_to    = 1'b1;
    end else if (m_held < 255) begin
      m_held++;
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic       d;
    logic [7:0] exp_g;

    // Fields: req, done, grant, grant_valid, sel, timeout (MAX_HOLD = 4).
    vecs[0]  = '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    vecs[1]  = '{8'h01, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0};
    vecs[4]  = '{8'h09, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0};
    vecs[5]  = '{8'h09, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    vecs[6]  = '{8'h09, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[7]  = '{8'h09, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0};
    vecs[8]  = '{8'h20, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0};
    vecs[9]  = '{8'h20, 1'b0, 8'h20, 1'b1, 3'd5, 1'b0};
    vecs[10] = '{8'h20, 1'b0, 8'h20, 1'b1, 3'd5, 1'b0};
    vecs[11] = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd5, 1'b0};
    vecs[12] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[13] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[14] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[15] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[16] = '{8'h04, 1'b0, 8'h00, 1'b0, 3'd2, 1'b1};
    vecs[17] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[18] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[19] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[20] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[21] = '{8'h04, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0};

    bus.req  = 8'h00;
    bus.done = 1'b0;
    rst      = 1'b1;
    #1;
    chk_all("async reset at start", 8'h00, 1'b0, 3'd0, 1'b0);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].req, vecs[i].done);
      chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].gv, vecs[i].sel, vecs[i].to);
    end

    // Full request vector: grants rotate 0..7 then wrap to 0, bubble between each.
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      cycle(8'hFF, 1'b0);
      exp_g = 8'h01 << (i % 8);
      chk_all($sformatf("rot%0d grant", i), exp_g, 1'b1, 3'(i % 8), 1'b0);
      cycle(8'hFF, 1'b1);
      chk_all($sformatf("rot%0d bubble", i), 8'h00, 1'b0, 3'(i % 8), 1'b0);
    end

    // Reset asserted between edges while a grant is active.
    do_reset();
    cycle(8'h02, 1'b0);
    chk_all("pre-rst grant", 8'h02, 1'b1, 3'd1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("mid-cycle rst", 8'h00, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 8'h80;
    #1;
    chk_all("after rst release", 8'h00, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("first grant after rst", 8'h80, 1'b1, 3'd7, 1'b0);

    // Random traffic against the model; requests change only occasionally so
    // holds last long enough to reach the timeout.
    do_reset();
    model_reset();
    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      end
      d = ($urandom_range(0, 9) == 0);
      cycle(r, d);
      model_step(r, d);
      exp_g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      chk_all($sformatf("rand%0d", i), exp_g, (m_owner >= 0), m_sel, m_to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
